// File: rtl/emib_rd_arbiter.sv
// Round-robin arbiter sharing the single EMIB configuration-RAM read port.
// Grants are combinational; issued reads return RD_LAT+2 cycles after handshake, tagged to the requester.
module emib_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_read_flash_done,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]        i_lock,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [ADDR_W-1:0]         o_emib_addr,
    output logic                      o_rd_ram_en,
    input  logic [15:0]               i_emib_data,
    output logic [15:0]               o_rd_data,
    output logic [NUM_REQ-1:0]        o_rd_vld,
    output logic                      o_busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] win_id;
    logic            xfer;
    int              scan_idx;

    logic [RD_LAT:0] tag_vld;
    logic [ID_W-1:0] tag_id [RD_LAT+1];

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        o_gnt    = '0;
        win_id   = '0;
        xfer     = 1'b0;
        scan_idx = 0;
        if (i_read_flash_done) begin
            if (state == ARB_LOCKED) begin
                o_gnt[owner] = i_req[owner];
                win_id       = owner;
                xfer         = i_req[owner];
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    scan_idx = int'(rr_ptr) + k;
                    if (scan_idx >= NUM_REQ) begin
                        scan_idx = scan_idx - NUM_REQ;
                    end
                    if (i_req[scan_idx]) begin
                        o_gnt           = '0;
                        o_gnt[scan_idx] = 1'b1;
                        win_id          = ID_W'(scan_idx);
                        xfer            = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ARB_OPEN;
            rr_ptr      <= '0;
            owner       <= '0;
            o_emib_addr <= '0;
            o_rd_ram_en <= 1'b0;
        end else begin
            o_rd_ram_en <= xfer;
            if (xfer) begin
                o_emib_addr <= i_req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                if (int'(win_id) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= win_id + ID_W'(1);
                end
                if (i_lock[win_id]) begin
                    state <= ARB_LOCKED;
                    owner <= win_id;
                end else begin
                    state <= ARB_OPEN;
                end
            end else if (state == ARB_LOCKED && !i_req[owner] && !i_lock[owner]) begin
                // Owner walked away from the lock without a closing read.
                state <= ARB_OPEN;
            end
        end
    end

    // Tag stage k is valid in cycle c+1+k; the last stage lines up with valid RAM data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld   <= '0;
            o_rd_data <= '0;
            o_rd_vld  <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[RD_LAT-1:0], xfer};
            tag_id[0] <= win_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            o_rd_vld <= '0;
            if (tag_vld[RD_LAT]) begin
                o_rd_data                <= i_emib_data;
                o_rd_vld[tag_id[RD_LAT]] <= 1'b1;
            end
        end
    end

    assign o_busy = o_rd_ram_en | (|tag_vld);

endmodule

// File: tb/tb_emib_rd_arbiter.sv
// Directed bench for emib_rd_arbiter: stimulus pushes expected returns into a scoreboard,
// a negedge monitor pops and compares them whenever o_rd_vld fires.
module tb_emib_rd_arbiter;

    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic        flash_done;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [9:0]  emib_addr;
    logic        rd_ram_en;
    logic [15:0] emib_data;
    logic [15:0] rd_data;
    logic [3:0]  rd_vld;
    logic        busy;

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [15:0] mem [1024];
    logic [15:0] ram_d0, ram_d1, ram_d2;
    int          cyc;
    int          checks;
    int          errors;
    logic        prev_en;
    logic [9:0]  prev_addr;

    emib_rd_arbiter dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_read_flash_done (flash_done),
        .i_req             (req),
        .i_req_addr        (req_addr),
        .i_lock            (lock),
        .o_gnt             (gnt),
        .o_emib_addr       (emib_addr),
        .o_rd_ram_en       (rd_ram_en),
        .i_emib_data       (emib_data),
        .o_rd_data         (rd_data),
        .o_rd_vld          (rd_vld),
        .o_busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Three-register RAM model: address presented in cycle n, data valid in cycle n+3.
    always @(posedge clk) begin
        ram_d0 <= mem[emib_addr];
        ram_d1 <= ram_d0;
        ram_d2 <= ram_d1;
    end
    assign emib_data = ram_d2;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive inputs just after the edge, check grant and the previous cycle's issue.
    task automatic applyStimulus(input logic fd, input logic [3:0] r, input logic [3:0] l,
                                 input logic [39:0] a, input logic [3:0] exp_gnt);
        logic [9:0] ga;
        @(posedge clk);
        #1;
        flash_done = fd;
        req        = r;
        lock       = l;
        req_addr   = a;
        @(negedge clk);
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("ram_en", 32'(rd_ram_en), 32'(prev_en));
        if (prev_en) checkOutput("emib_addr", 32'(emib_addr), 32'(prev_addr));
        ga = '0;
        for (int i = 0; i < 4; i++) begin
            if (exp_gnt[i]) ga = a[i*10 +: 10];
        end
        prev_en   = (exp_gnt != 4'b0);
        prev_addr = ga;
        if (exp_gnt != 4'b0) sb.push_back('{vld: exp_gnt, data: mem[ga], cyc: cyc + LAT});
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 4'b0, 4'b0, 40'h0, 4'b0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        req  = 4'b0;
        lock = 4'b0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_ram_en", 32'(rd_ram_en), 0);
        checkOutput("rst_emib_addr", 32'(emib_addr), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_rd_vld", 32'(rd_vld), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        sb.delete();
        prev_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: flags late, missing, unexpected or wrong returns.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_missing: got no return expected vld 0x%0h by cycle %0d", sb[0].vld, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (rd_vld != 4'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rd_unexpected: got vld 0x%0h expected none (cycle %0d)", rd_vld, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("rd_vld", 32'(rd_vld), 32'(mon_e.vld));
                    checkOutput("rd_data", 32'(rd_data), 32'(mon_e.data));
                    checkOutput("rd_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        prev_en = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37) ^ 16'hC3A5;
        mem[10'h02C] = 16'h1234;
        rst        = 1'b1;
        flash_done = 1'b0;
        req        = 4'b0;
        lock       = 4'b0;
        req_addr   = 40'h0;
        #2;
        checkOutput("init_gnt", 32'(gnt), 0);
        checkOutput("init_ram_en", 32'(rd_ram_en), 0);
        checkOutput("init_emib_addr", 32'(emib_addr), 0);
        checkOutput("init_rd_data", 32'(rd_data), 0);
        checkOutput("init_rd_vld", 32'(rd_vld), 0);
        checkOutput("init_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] flash not loaded, all requesting");
        repeat (10) applyStimulus(1'b0, 4'hF, 4'h0, {10'h3, 10'h2, 10'h1, 10'h0}, 4'b0);

        $display("[TB] single read, req0 addr 0x2C");
        applyStimulus(1'b1, 4'b0001, 4'b0, {30'h0, 10'h02C}, 4'b0001);
        applyStimulus(1'b1, 4'b0000, 4'b0, 40'h0, 4'b0);
        checkOutput("busy_inflight", 32'(busy), 1);
        idle(6);
        checkOutput("busy_drained", 32'(busy), 0);
        checkOutput("rd_data_hold", 32'(rd_data), 32'h1234);

        $display("[TB] round robin, all requesting");
        doReset();
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 4'hF, 4'h0, {10'h103, 10'h102, 10'h101, 10'h100}, 4'(1 << (k % 4)));
        idle(6);

        $display("[TB] lock by req1 with flash drop");
        applyStimulus(1'b1, 4'b0001, 4'b0000, {30'h0, 10'h010}, 4'b0001);
        applyStimulus(1'b1, 4'b0111, 4'b0010, {10'd0, 10'h012, 10'd44, 10'h010}, 4'b0010);
        applyStimulus(1'b0, 4'b0111, 4'b0010, {10'd0, 10'h012, 10'd45, 10'h010}, 4'b0000);
        applyStimulus(1'b0, 4'b0111, 4'b0010, {10'd0, 10'h012, 10'd45, 10'h010}, 4'b0000);
        applyStimulus(1'b1, 4'b0111, 4'b0010, {10'd0, 10'h012, 10'd45, 10'h010}, 4'b0010);
        applyStimulus(1'b1, 4'b0111, 4'b0000, {10'd0, 10'h012, 10'd46, 10'h010}, 4'b0010);
        applyStimulus(1'b1, 4'b0101, 4'b0000, {10'd0, 10'h012, 10'd46, 10'h010}, 4'b0100);
        applyStimulus(1'b1, 4'b0001, 4'b0000, {10'd0, 10'h012, 10'd46, 10'h010}, 4'b0001);
        idle(6);

        $display("[TB] reset with reads in flight");
        applyStimulus(1'b1, 4'b0001, 4'b0, {30'h0, 10'h020}, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 4'b0, {30'h0, 10'h021}, 4'b0001);
        doReset();
        idle(6);
        applyStimulus(1'b1, 4'b0001, 4'b0, {30'h0, 10'h06F}, 4'b0001);
        idle(6);

        $display("[TB] lock abandoned by owner");
        applyStimulus(1'b1, 4'b0001, 4'b0001, {10'h033, 20'h0, 10'h030}, 4'b0001);
        applyStimulus(1'b1, 4'b1000, 4'b0000, {10'h033, 20'h0, 10'h030}, 4'b0000);
        applyStimulus(1'b1, 4'b1000, 4'b0000, {10'h033, 20'h0, 10'h030}, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 40'h0, 4'b0000);
        applyStimulus(1'b1, 4'b0101, 4'b0000, {10'h0, 10'h040, 10'h0, 10'h041}, 4'b0001);
        applyStimulus(1'b1, 4'b0100, 4'b0000, {10'h0, 10'h040, 10'h0, 10'h041}, 4'b0100);
        idle(6);

        checkOutput("busy_final", 32'(busy), 0);
        checkOutput("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
